// File: rtl/vga_param_ctrl.sv
// ---------------------------------------------------------------------------
// vga_param_ctrl
//   Parameterised VGA timing generator with a built-in test-pattern source.
//   The h/v counters define the raster. Request-side signals (o_pix_req,
//   o_pix_x, o_pix_y, o_frame_start) are combinational from the counters.
//   Sync, active flag and coordinates are delayed by PIX_LAT clocks so that
//   they line up with the external pixel source. A final output register then
//   drives the DAC, so the DAC outputs for a position appear PIX_LAT+1 clocks
//   after that position's request.
//
// Ports
//   clk            pixel clock
//   rst_n          asynchronous active-low reset
//   i_mode[1:0]    0 external, 1 colour bars, 2 checkerboard, 3 black
//   i_pix_rgb[23:0] external pixel {R,G,B}, valid PIX_LAT clocks after request
//   o_pix_req      request for the current active-area position
//   o_pix_x/o_pix_y active-area coordinate (0 when o_pix_req is low)
//   o_frame_start  one-clock pulse at h=0, v=0
//   o_vga_r/g/b    DAC colour
//   o_vga_hs/vs    active-low sync
//   o_vga_blank    DAC BLANK_N (high in active video)
//   o_vga_sync     DAC SYNC_N, tied low
//   o_vga_clk      inverted pixel clock for the DAC
// ---------------------------------------------------------------------------
module vga_param_ctrl #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_DISP  = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 10,
    parameter int CW      = 11,
    parameter int PIX_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    i_mode,
    input  logic [23:0]   i_pix_rgb,
    output logic          o_pix_req,
    output logic [CW-1:0] o_pix_x,
    output logic [CW-1:0] o_pix_y,
    output logic          o_frame_start,
    output logic [7:0]    o_vga_r,
    output logic [7:0]    o_vga_g,
    output logic [7:0]    o_vga_b,
    output logic          o_vga_hs,
    output logic          o_vga_vs,
    output logic          o_vga_blank,
    output logic          o_vga_sync,
    output logic          o_vga_clk
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_ACT0  = H_SYNC + H_BACK;
    localparam int H_ACT1  = H_ACT0 + H_DISP;
    localparam int V_ACT0  = V_SYNC + V_BACK;
    localparam int V_ACT1  = V_ACT0 + V_DISP;
    localparam int BAR_W   = H_DISP / 8;
    // Delay-line word: {hs_raw, vs_raw, active, x, y}
    localparam int DW      = 3 + 2 * CW;
    // Sync bits reset to their inactive (high) level
    localparam logic [DW-1:0] DL_RST = {2'b11, {(DW-2){1'b0}}};

    // ---------------- raster counters ----------------
    logic [CW-1:0] h_reg, v_reg;
    logic          h_wrap, v_wrap;

    assign h_wrap = (h_reg == CW'(H_TOTAL - 1));
    assign v_wrap = (v_reg == CW'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg <= '0;
            v_reg <= '0;
        end else if (h_wrap) begin
            h_reg <= '0;
            v_reg <= v_wrap ? '0 : v_reg + CW'(1);
        end else begin
            h_reg <= h_reg + CW'(1);
        end
    end

    // ---------------- request side ----------------
    logic hs_raw, vs_raw, active, frame_pos;

    assign hs_raw    = !(h_reg < CW'(H_SYNC));
    assign vs_raw    = !(v_reg < CW'(V_SYNC));
    assign active    = (h_reg >= CW'(H_ACT0)) && (h_reg < CW'(H_ACT1)) &&
                       (v_reg >= CW'(V_ACT0)) && (v_reg < CW'(V_ACT1));
    assign frame_pos = (h_reg == '0) && (v_reg == '0);

    assign o_pix_req     = active;
    assign o_pix_x       = active ? (h_reg - CW'(H_ACT0)) : '0;
    assign o_pix_y       = active ? (v_reg - CW'(V_ACT0)) : '0;
    // Counters sit at 0,0 during reset; gate with rst_n so the pulse is low
    // while reset is held and high in the first clock after release.
    assign o_frame_start = rst_n & frame_pos;

    // ---------------- mode latch ----------------
    logic [1:0] mode_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_reg <= 2'd0;
        else if (frame_pos)
            mode_reg <= i_mode;
    end

    // ---------------- PIX_LAT delay line ----------------
    logic [DW-1:0] dl_in, dl_out;

    assign dl_in = {hs_raw, vs_raw, active, o_pix_x, o_pix_y};

    generate
        if (PIX_LAT == 0) begin : g_no_dl
            assign dl_out = dl_in;
        end else begin : g_dl
            logic [DW-1:0] dl_reg [PIX_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIX_LAT; i++)
                        dl_reg[i] <= DL_RST;
                end else begin
                    dl_reg[0] <= dl_in;
                    for (int i = 1; i < PIX_LAT; i++)
                        dl_reg[i] <= dl_reg[i-1];
                end
            end

            assign dl_out = dl_reg[PIX_LAT-1];
        end
    endgenerate

    logic          hs_d, vs_d, act_d;
    logic [CW-1:0] x_d, y_d;

    assign hs_d  = dl_out[DW-1];
    assign vs_d  = dl_out[DW-2];
    assign act_d = dl_out[DW-3];
    assign x_d   = dl_out[2*CW-1:CW];
    assign y_d   = dl_out[CW-1:0];

    // Only bit 5 of the delayed y feeds the checkerboard.
    logic unused_y;
    assign unused_y = ^y_d;

    // ---------------- pattern generation ----------------
    logic [CW-1:0] bar_idx;
    logic [23:0]   bar_rgb;
    logic [23:0]   rgb_next;

    assign bar_idx = x_d / CW'(BAR_W);

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            CW'(0):  bar_rgb = 24'hFFFFFF;  // white
            CW'(1):  bar_rgb = 24'hFFFF00;  // yellow
            CW'(2):  bar_rgb = 24'h00FFFF;  // cyan
            CW'(3):  bar_rgb = 24'h00FF00;  // green
            CW'(4):  bar_rgb = 24'hFF00FF;  // magenta
            CW'(5):  bar_rgb = 24'hFF0000;  // red
            CW'(6):  bar_rgb = 24'h0000FF;  // blue
            default: bar_rgb = 24'h000000;  // bar 7 and remainder pixels
        endcase
    end

    always_comb begin
        rgb_next = 24'h000000;
        if (act_d) begin
            case (mode_reg)
                2'd0:    rgb_next = i_pix_rgb;
                2'd1:    rgb_next = bar_rgb;
                2'd2:    rgb_next = (x_d[5] ^ y_d[5]) ? 24'h000000 : 24'hFFFFFF;
                default: rgb_next = 24'h000000;
            endcase
        end
    end

    // ---------------- DAC output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_vga_hs    <= 1'b1;
            o_vga_vs    <= 1'b1;
            o_vga_blank <= 1'b0;
            o_vga_r     <= 8'h00;
            o_vga_g     <= 8'h00;
            o_vga_b     <= 8'h00;
        end else begin
            o_vga_hs    <= hs_d;
            o_vga_vs    <= vs_d;
            o_vga_blank <= act_d;
            {o_vga_r, o_vga_g, o_vga_b} <= rgb_next;
        end
    end

    assign o_vga_sync = 1'b0;
    assign o_vga_clk  = ~clk;

endmodule

// File: tb/tb_vga_param_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_param_ctrl
//   Two instances on a shrunken raster: dut_a with PIX_LAT=1, dut_b with
//   PIX_LAT=3, sharing clock, reset and mode. Each has its own external pixel
//   source producing {x[7:0], y[7:0], A5} PIX_LAT clocks after a request, and
//   random junk for non-requests. The expected raster is derived from a cycle
//   index since reset release using plain div/mod arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_param_ctrl;

    localparam int HS = 8, HB = 6, HD = 84, HF = 4;
    localparam int VS = 2, VB = 3, VD = 40, VF = 2;
    localparam int CW = 8;
    localparam int HT = HS + HB + HD + HF;   // 102
    localparam int VT = VS + VB + VD + VF;   // 47
    localparam int FT = HT * VT;             // 4794
    localparam int HA0 = HS + HB;
    localparam int VA0 = VS + VB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] i_mode = 2'd0;

    always #5 clk = ~clk;

    // dut_a signals (PIX_LAT=1)
    logic [23:0] rgb_in_a;
    logic req_a, fs_a, hs_a, vs_a, blank_a, sync_a, vclk_a;
    logic [CW-1:0] x_a, y_a;
    logic [7:0] r_a, g_a, b_a;
    // dut_b signals (PIX_LAT=3)
    logic [23:0] rgb_in_b;
    logic req_b, fs_b, hs_b, vs_b, blank_b, sync_b, vclk_b;
    logic [CW-1:0] x_b, y_b;
    logic [7:0] r_b, g_b, b_b;

    vga_param_ctrl #(.H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
                     .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
                     .CW(CW), .PIX_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_mode(i_mode), .i_pix_rgb(rgb_in_a),
        .o_pix_req(req_a), .o_pix_x(x_a), .o_pix_y(y_a), .o_frame_start(fs_a),
        .o_vga_r(r_a), .o_vga_g(g_a), .o_vga_b(b_a), .o_vga_hs(hs_a),
        .o_vga_vs(vs_a), .o_vga_blank(blank_a), .o_vga_sync(sync_a),
        .o_vga_clk(vclk_a));

    vga_param_ctrl #(.H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
                     .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
                     .CW(CW), .PIX_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_mode(i_mode), .i_pix_rgb(rgb_in_b),
        .o_pix_req(req_b), .o_pix_x(x_b), .o_pix_y(y_b), .o_frame_start(fs_b),
        .o_vga_r(r_b), .o_vga_g(g_b), .o_vga_b(b_b), .o_vga_hs(hs_b),
        .o_vga_vs(vs_b), .o_vga_blank(blank_b), .o_vga_sync(sync_b),
        .o_vga_clk(vclk_b));

    // External pixel sources with PIX_LAT read latency
    logic [15:0] pipe_a [1];
    logic [15:0] pipe_b [3];
    always @(posedge clk) begin
        pipe_a[0] <= req_a ? {x_a, y_a} : 16'($urandom);
        pipe_b[0] <= req_b ? {x_b, y_b} : 16'($urandom);
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rgb_in_a = {pipe_a[0], 8'hA5};
    assign rgb_in_b = {pipe_b[2], 8'hA5};

    // Cycle index since reset release, and the mode each frame latched
    int n;
    int mode_hist [64];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end
    always @(posedge clk) begin
        if (rst_n && (n % FT == 0))
            mode_hist[(n / FT) % 64] <= int'(i_mode);
    end

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          x;
        int          y;
        logic        blank;
        logic [23:0] rgb;
    } pt_t;

    // ---------------- reference model ----------------
    function automatic logic [23:0] colour(input int mode, input int x, input int y);
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        case (mode)
            0:       return {8'(x % 256), 8'(y % 256), 8'hA5};
            1:       return ((x / (HD / 8)) < 8) ? bars[x / (HD / 8)] : 24'h000000;
            2:       return ((((x / 32) + (y / 32)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            default: return 24'h000000;
        endcase
    endfunction

    // {hs, vs, blank, rgb} expected at cycle nn for a DUT with latency lat
    function automatic logic [26:0] exp_dac(input int nn, input int lat);
        int p, h, v;
        logic act;
        p = nn - lat - 1;
        if (p < 0) return {1'b1, 1'b1, 1'b0, 24'h000000};
        h = p % HT;
        v = (p / HT) % VT;
        act = (h >= HA0) && (h < HA0 + HD) && (v >= VA0) && (v < VA0 + VD);
        return {h >= HS, v >= VS, act,
                act ? colour(mode_hist[(p / FT) % 64], h - HA0, v - VA0) : 24'h000000};
    endfunction

    // {frame_start, req, x, y} expected at cycle nn
    function automatic logic [2*CW+1:0] exp_req(input int nn);
        int h, v;
        logic act;
        h = nn % HT;
        v = (nn / HT) % VT;
        act = (h >= HA0) && (h < HA0 + HD) && (v >= VA0) && (v < VA0 + VD);
        return {(h == 0) && (v == 0), act,
                act ? CW'(h - HA0) : CW'(0), act ? CW'(v - VA0) : CW'(0)};
    endfunction

    task automatic wait_n(input int t);
        while (n < t) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        i_mode = 2'd2;
        repeat (3) @(negedge clk);
        vectors++;
        if ({hs_a, vs_a, blank_a, r_a, g_a, b_a, fs_a} !== {1'b1, 1'b1, 1'b0, 24'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_a got %h want %h", {hs_a, vs_a, blank_a, r_a, g_a, b_a, fs_a},
                     {1'b1, 1'b1, 1'b0, 24'h0, 1'b0});
        end
        vectors++;
        if ({hs_b, vs_b, blank_b, r_b, g_b, b_b, fs_b} !== {1'b1, 1'b1, 1'b0, 24'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_b got %h want %h", {hs_b, vs_b, blank_b, r_b, g_b, b_b, fs_b},
                     {1'b1, 1'b1, 1'b0, 24'h0, 1'b0});
        end
        vectors++;
        if ({sync_a, vclk_a, sync_b, vclk_b} !== {1'b0, ~clk, 1'b0, ~clk}) begin
            miscompares++;
            $display("FAIL sync_clk got %b want %b", {sync_a, vclk_a, sync_b, vclk_b},
                     {1'b0, ~clk, 1'b0, ~clk});
        end
        i_mode = 2'd0;
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({fs_a, req_a, x_a, y_a} !== exp_req(0)) begin
            miscompares++;
            $display("FAIL release_req_a got %h want %h", {fs_a, req_a, x_a, y_a}, exp_req(0));
        end
        vectors++;
        if ({fs_b, req_b, x_b, y_b} !== exp_req(0)) begin
            miscompares++;
            $display("FAIL release_req_b got %h want %h", {fs_b, req_b, x_b, y_b}, exp_req(0));
        end
    endtask

    task automatic test_frame_timing();
        int hs_low = 0, vs_low = 0, fs_cnt = 0, fs_second = -1, req_cnt = 0;
        int first_req = -1, first_blank = -1;
        logic [2*CW-1:0] first_xy = '1;
        for (int k = 0; k < 2 * FT; k++) begin
            if (k > 0) @(negedge clk);
            hs_low += int'(!hs_a);
            vs_low += int'(!vs_a);
            req_cnt += int'(req_a);
            if (fs_a) begin
                fs_cnt++;
                if (fs_cnt == 2) fs_second = k;
            end
            if (req_a && first_req < 0) begin
                first_req = k;
                first_xy = {x_a, y_a};
            end
            if (blank_a && first_blank < 0) first_blank = k;
        end
        vectors++;
        if (hs_low != 2 * VT * HS) begin
            miscompares++;
            $display("FAIL hs_low_count got %0d want %0d", hs_low, 2 * VT * HS);
        end
        vectors++;
        if (vs_low != 2 * VS * HT) begin
            miscompares++;
            $display("FAIL vs_low_count got %0d want %0d", vs_low, 2 * VS * HT);
        end
        vectors++;
        if (fs_cnt != 2 || fs_second != FT) begin
            miscompares++;
            $display("FAIL frame_period got cnt=%0d at=%0d want cnt=2 at=%0d", fs_cnt, fs_second, FT);
        end
        vectors++;
        if (req_cnt != 2 * HD * VD) begin
            miscompares++;
            $display("FAIL req_count got %0d want %0d", req_cnt, 2 * HD * VD);
        end
        vectors++;
        if (first_req != VA0 * HT + HA0 || first_xy !== '0) begin
            miscompares++;
            $display("FAIL first_req got n=%0d xy=%h want n=%0d xy=0", first_req, first_xy, VA0 * HT + HA0);
        end
        vectors++;
        if (first_blank != first_req + 2) begin
            miscompares++;
            $display("FAIL first_blank got %0d want %0d", first_blank, first_req + 2);
        end
    endtask

    task automatic test_random_frames();
        int start;
        start = int'($urandom % 4);
        repeat (4 * FT) begin
            @(posedge clk);
            #1;
            if (n % FT == 0) i_mode = 2'((start + n / FT) % 4);
            else             i_mode = 2'($urandom);
            @(negedge clk);
            vectors++;
            if ({fs_a, req_a, x_a, y_a} !== exp_req(n)) begin
                miscompares++;
                $display("FAIL req_a n=%0d got %h want %h", n, {fs_a, req_a, x_a, y_a}, exp_req(n));
            end
            vectors++;
            if ({fs_b, req_b, x_b, y_b} !== exp_req(n)) begin
                miscompares++;
                $display("FAIL req_b n=%0d got %h want %h", n, {fs_b, req_b, x_b, y_b}, exp_req(n));
            end
            vectors++;
            if ({hs_a, vs_a, blank_a, r_a, g_a, b_a} !== exp_dac(n, 1)) begin
                miscompares++;
                $display("FAIL dac_a n=%0d got %h want %h", n, {hs_a, vs_a, blank_a, r_a, g_a, b_a}, exp_dac(n, 1));
            end
            vectors++;
            if ({hs_b, vs_b, blank_b, r_b, g_b, b_b} !== exp_dac(n, 3)) begin
                miscompares++;
                $display("FAIL dac_b n=%0d got %h want %h", n, {hs_b, vs_b, blank_b, r_b, g_b, b_b}, exp_dac(n, 3));
            end
        end
    endtask

    // Hard-coded pixels of one frame in mode m, checked on both instances
    task automatic test_pattern_points(input int m, input pt_t pts[$]);
        int base, pos;
        @(negedge clk);
        i_mode = 2'(m);
        base = (n / FT + 1) * FT;
        while (n < base + FT) begin
            @(negedge clk);
            for (int i = 0; i < pts.size(); i++) begin
                pos = base + (VA0 + pts[i].y) * HT + HA0 + pts[i].x;
                if (n == pos + 2) begin
                    vectors++;
                    if ({blank_a, r_a, g_a, b_a} !== {pts[i].blank, pts[i].rgb}) begin
                        miscompares++;
                        $display("FAIL pt_a mode=%0d (%0d,%0d) got %h want %h", m, pts[i].x, pts[i].y,
                                 {blank_a, r_a, g_a, b_a}, {pts[i].blank, pts[i].rgb});
                    end
                end
                if (n == pos + 4) begin
                    vectors++;
                    if ({blank_b, r_b, g_b, b_b} !== {pts[i].blank, pts[i].rgb}) begin
                        miscompares++;
                        $display("FAIL pt_b mode=%0d (%0d,%0d) got %h want %h", m, pts[i].x, pts[i].y,
                                 {blank_b, r_b, g_b, b_b}, {pts[i].blank, pts[i].rgb});
                    end
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        int base;
        @(negedge clk);
        i_mode = 2'd2;
        base = (n / FT + 1) * FT;
        wait_n(base + (VA0 + 10) * HT);
        i_mode = 2'd3;
        wait_n(base + (VA0 + 32) * HT + HA0 + 32 + 2);
        vectors++;
        if ({blank_a, r_a, g_a, b_a} !== {1'b1, 24'hFFFFFF}) begin
            miscompares++;
            $display("FAIL switch_same_frame got %h want %h", {blank_a, r_a, g_a, b_a}, {1'b1, 24'hFFFFFF});
        end
        base = base + FT;
        wait_n(base + VA0 * HT + HA0 + 2);
        vectors++;
        if ({blank_a, r_a, g_a, b_a} !== {1'b1, 24'h000000}) begin
            miscompares++;
            $display("FAIL switch_next_origin got %h want %h", {blank_a, r_a, g_a, b_a}, {1'b1, 24'h000000});
        end
        wait_n(base + (VA0 + 32) * HT + HA0 + 32 + 2);
        vectors++;
        if ({blank_a, r_a, g_a, b_a} !== {1'b1, 24'h000000}) begin
            miscompares++;
            $display("FAIL switch_next_32_32 got %h want %h", {blank_a, r_a, g_a, b_a}, {1'b1, 24'h000000});
        end
    endtask

    task automatic test_reset_midframe();
        int base, fs_at;
        @(negedge clk);
        i_mode = 2'd1;
        base = (n / FT + 1) * FT;
        wait_n(base + 20 * HT + 30);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({hs_a, vs_a, blank_a, r_a, g_a, b_a} !== {1'b1, 1'b1, 1'b0, 24'h0}) begin
            miscompares++;
            $display("FAIL midreset_dac_a got %h want %h", {hs_a, vs_a, blank_a, r_a, g_a, b_a}, {1'b1, 1'b1, 1'b0, 24'h0});
        end
        vectors++;
        if ({hs_b, vs_b, blank_b, r_b, g_b, b_b} !== {1'b1, 1'b1, 1'b0, 24'h0}) begin
            miscompares++;
            $display("FAIL midreset_dac_b got %h want %h", {hs_b, vs_b, blank_b, r_b, g_b, b_b}, {1'b1, 1'b1, 1'b0, 24'h0});
        end
        vectors++;
        if ({fs_a, req_a, x_a, y_a, fs_b, req_b, x_b, y_b} !== '0) begin
            miscompares++;
            $display("FAIL midreset_req got %h want 0", {fs_a, req_a, x_a, y_a, fs_b, req_b, x_b, y_b});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({fs_a, fs_b} !== 2'b11) begin
            miscompares++;
            $display("FAIL midreset_release_fs got %b want 11", {fs_a, fs_b});
        end
        fs_at = -1;
        repeat (FT + 8) begin
            @(posedge clk);
            #1;
            i_mode = 2'($urandom);
            @(negedge clk);
            if (fs_a && fs_at < 0) fs_at = n;
            vectors++;
            if ({fs_a, req_a, x_a, y_a} !== exp_req(n)) begin
                miscompares++;
                $display("FAIL after_reset_req_a n=%0d got %h want %h", n, {fs_a, req_a, x_a, y_a}, exp_req(n));
            end
            vectors++;
            if ({hs_a, vs_a, blank_a, r_a, g_a, b_a} !== exp_dac(n, 1)) begin
                miscompares++;
                $display("FAIL after_reset_dac_a n=%0d got %h want %h", n, {hs_a, vs_a, blank_a, r_a, g_a, b_a}, exp_dac(n, 1));
            end
            vectors++;
            if ({hs_b, vs_b, blank_b, r_b, g_b, b_b} !== exp_dac(n, 3)) begin
                miscompares++;
                $display("FAIL after_reset_dac_b n=%0d got %h want %h", n, {hs_b, vs_b, blank_b, r_b, g_b, b_b}, exp_dac(n, 3));
            end
        end
        vectors++;
        if (fs_at != FT) begin
            miscompares++;
            $display("FAIL after_reset_frame_period got %0d want %0d", fs_at, FT);
        end
    endtask

    initial begin
        pt_t bars_q[$];
        pt_t chk_q[$];
        pt_t ext_q[$];

        bars_q.push_back(pt_t'{-1, 0, 1'b0, 24'h000000});
        bars_q.push_back(pt_t'{9,  0, 1'b1, 24'hFFFFFF});
        bars_q.push_back(pt_t'{10, 0, 1'b1, 24'hFFFF00});
        bars_q.push_back(pt_t'{20, 0, 1'b1, 24'h00FFFF});
        bars_q.push_back(pt_t'{35, 1, 1'b1, 24'h00FF00});
        bars_q.push_back(pt_t'{45, 1, 1'b1, 24'hFF00FF});
        bars_q.push_back(pt_t'{55, 2, 1'b1, 24'hFF0000});
        bars_q.push_back(pt_t'{69, 2, 1'b1, 24'h0000FF});
        bars_q.push_back(pt_t'{79, 3, 1'b1, 24'h000000});
        bars_q.push_back(pt_t'{83, 3, 1'b1, 24'h000000});
        bars_q.push_back(pt_t'{84, 5, 1'b0, 24'h000000});

        chk_q.push_back(pt_t'{31, 0,  1'b1, 24'hFFFFFF});
        chk_q.push_back(pt_t'{32, 0,  1'b1, 24'h000000});
        chk_q.push_back(pt_t'{0,  32, 1'b1, 24'h000000});
        chk_q.push_back(pt_t'{32, 32, 1'b1, 24'hFFFFFF});

        ext_q.push_back(pt_t'{5,  7,  1'b1, 24'h0507A5});
        ext_q.push_back(pt_t'{84, 7,  1'b0, 24'h000000});
        ext_q.push_back(pt_t'{83, 39, 1'b1, 24'h5327A5});

        test_reset();
        test_frame_timing();
        test_random_frames();
        test_pattern_points(1, bars_q);
        test_pattern_points(2, chk_q);
        test_pattern_points(0, ext_q);
        test_mode_switch();
        test_reset_midframe();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached, n=%0d", n);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_param_ctrl.md
VGA_PARAM_CTRL -- requirements
Module: vga_param_ctrl

Interface
REQ-001 Parameter H_SYNC, 96, horizontal sync width in pixel clocks.
REQ-002 Parameter H_BACK, 48, horizontal back porch.
REQ-003 Parameter H_DISP, 640, active pixels per line.
REQ-004 Parameter H_FRONT, 16, horizontal front porch.
REQ-005 Parameter V_SYNC, 2; V_BACK, 33; V_DISP, 480; V_FRONT, 10; vertical equivalents in lines.
REQ-006 Parameter CW, 11, counter and coordinate width; SHALL hold max(H_TOTAL, V_TOTAL)-1.
REQ-007 Parameter PIX_LAT, 1, pixel-source read latency in clocks; legal range 0..4.
REQ-008 clk  in  1  pixel clock, single clock domain.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 i_mode  in  2  0 external pixels, 1 colour bars, 2 checkerboard, 3 solid black.
REQ-011 i_pix_rgb  in  24  external pixel {R,G,B}, valid PIX_LAT clocks after its o_pix_req.
REQ-012 o_pix_req  out  1  pixel request, high for every active-area position.
REQ-013 o_pix_x / o_pix_y  out  CW each  active-area coordinate of current request; 0 when o_pix_req low.
REQ-014 o_frame_start  out  1  one-clock pulse at counter position h=0, v=0.
REQ-015 o_vga_r / o_vga_g / o_vga_b  out  8 each  DAC colour.
REQ-016 o_vga_hs / o_vga_vs  out  1 each  sync, active low.
REQ-017 o_vga_blank  out  1  DAC BLANK_N: high in active video, low otherwise.
REQ-018 o_vga_sync  out  1  tied 0.  o_vga_clk  out  1  ~clk.

Function
REQ-019 H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL likewise; region order per line/frame: sync, back, display, front.
REQ-020 h counter SHALL count 0..H_TOTAL-1 and wrap to 0; v counter SHALL increment only when h wraps, count 0..V_TOTAL-1, wrap to 0.
REQ-021 Request-side hs_raw low for h<H_SYNC; vs_raw low for v<V_SYNC.
REQ-022 Active when H_SYNC+H_BACK <= h < H_SYNC+H_BACK+H_DISP and V_SYNC+V_BACK <= v < V_SYNC+V_BACK+V_DISP; o_pix_req, o_pix_x = h-(H_SYNC+H_BACK), o_pix_y = v-(V_SYNC+V_BACK) SHALL be combinational from counters.
REQ-023 hs_raw, vs_raw, active and coordinates SHALL pass through a PIX_LAT-deep delay line, then one output register; all o_vga_* (except clk, sync) for a position SHALL appear together PIX_LAT+1 clocks after its request.
REQ-024 Mode 0: output register SHALL capture i_pix_rgb when delayed active is high.
REQ-025 Mode 1: eight bars of width H_DISP/8 indexed by x/(H_DISP/8), order white, yellow, cyan, green, magenta, red, blue, black; remainder pixels black.
REQ-026 Mode 2: 32x32 checkerboard, white when x[5] XOR y[5] = 0, else black.
REQ-027 Mode 3: all channels 0.
REQ-028 Outside active area RGB SHALL be 0 regardless of mode or i_pix_rgb.
REQ-029 i_mode SHALL be sampled only in the o_frame_start clock; mid-frame changes take effect next frame.
REQ-030 Colours: white FF/FF/FF, yellow FF/FF/00, cyan 00/FF/FF, green 00/FF/00, magenta FF/00/FF, red FF/00/00, blue 00/00/FF.

Reset
REQ-031 On rst_n low, immediately: counters 0, delay line cleared, latched mode 0, o_vga_hs=1, o_vga_vs=1, o_vga_blank=0, RGB=0, o_frame_start=0.
REQ-032 First clock after rst_n release SHALL be position h=0, v=0 with o_frame_start high; reset mid-line SHALL abandon the frame without glitching sync high-to-low before counting resumes.

Verification
REQ-033 Defaults, run 2 frames -> hs low 96 of every 800 clocks; vs low 1600 of every 420000 clocks; o_frame_start period 420000.
REQ-034 Defaults, PIX_LAT=1 -> first o_pix_req at h=144, v=35 with x=0,y=0; first o_vga_blank high 2 clocks later; 640x480 requests per frame.
REQ-035 Mode 0, i_pix_rgb = {x[7:0], y[7:0], 8'hA5} model -> DAC pixel (5,7) = 05/07/A5; PIX_LAT=3 rebuild gives identical image.
REQ-036 Mode 1 -> pixel x=79 white, x=80 yellow, x=639 black; blank region RGB 0.
REQ-037 Mode 2 -> (31,0) white, (32,0) black, (32,32) white; switch to mode 3 mid-frame -> change visible only after next o_frame_start.
REQ-038 Assert rst_n low at h=300, v=200 -> outputs at reset values same cycle; after release, o_frame_start next clock, full frame timing as REQ-033.
